// File: rtl/event_framer.sv
// event_framer: buffers a non-stallable 32-bit sample stream, splits it into
// packets and frames each one with a 3-word header (sync+seq, 64-bit start
// timestamp) and a 1-word trailer (word count, overflow flag) on an
// AXI-Stream master.
module event_framer #(
  parameter int unsigned FIFO_AW   = 10,
  parameter int unsigned HDR_AW    = 2,
  parameter logic [15:0] SYNC_WORD = 16'hEF5A
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  input  logic [31:0]        s_axis_tdata,
  input  logic [63:0]        timestamp,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tlast,
  output logic [31:0]        packets_sent,
  output logic [15:0]        packets_dropped,
  output logic [31:0]        words_dropped,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy
);

  localparam int unsigned DDEPTH_N = 1 << FIFO_AW;
  localparam int unsigned HDEPTH_N = 1 << HDR_AW;
  localparam logic [FIFO_AW+1:0] DDEPTH = (FIFO_AW+2)'(DDEPTH_N);
  localparam logic [FIFO_AW+1:0] FREE_1 = (FIFO_AW+2)'(1);
  localparam logic [FIFO_AW+1:0] FREE_2 = (FIFO_AW+2)'(2);

  typedef enum logic [2:0] {IDLE, H0, H1, H2, PAY, TRL} state_t;

  // Data FIFO: entries are {eop, ovf, data}
  logic [33:0]        dmem [DDEPTH_N];
  logic [FIFO_AW-1:0] dwr_ptr;
  logic [FIFO_AW-1:0] drd_ptr;
  logic [FIFO_AW:0]   dcount;
  logic               dwr_en;
  logic               drd_en;
  logic [33:0]        dwr_data;
  logic [33:0]        drd_data;
  logic [FIFO_AW+1:0] dfree;

  // Header FIFO: entries are {seq, timestamp}
  logic [79:0]        hmem [HDEPTH_N];
  logic [HDR_AW-1:0]  hwr_ptr;
  logic [HDR_AW-1:0]  hrd_ptr;
  logic [HDR_AW:0]    hcount;
  logic               hpush;
  logic               hpop;
  logic               hfull;
  logic               hempty;
  logic [79:0]        hhead;

  // Input side
  logic               in_pkt;
  logic               discard;
  logic [15:0]        seq;
  logic               pkt_ovf;
  logic               hold_valid;
  logic               hold_last;
  logic [31:0]        hold_data;
  logic               eop_now;
  logic               sop;
  logic               accept_word;
  logic               word_drop;

  // Output side
  state_t             state;
  logic               cur_eop;
  logic               cur_ovf;
  logic [15:0]        pay_count;
  logic               accept;
  logic               can_load;
  logic               pay_done;
  logic               h2_load;
  logic               pay_load;

  assign hfull    = hcount[HDR_AW];
  assign hempty   = (hcount == '0);
  assign hhead    = hmem[hrd_ptr];
  assign drd_data = dmem[drd_ptr];
  assign hpush    = sop && !hfull;
  assign hpop     = (state == TRL) && accept;

  assign fifo_level = dcount;
  assign busy       = (dcount != '0) || !hempty || (state != IDLE);

  // Input-side decode: packet boundaries, hold-register writeback and space rule.
  // A tlast word held last cycle closes its packet now, so a valid word in the
  // same cycle is already a new SOP.
  always_comb begin
    eop_now     = hold_valid && (hold_last || !s_axis_tvalid);
    sop         = s_axis_tvalid && (!in_pkt || (!discard && eop_now));
    accept_word = s_axis_tvalid && (sop ? !hfull : !discard);
    dfree       = DDEPTH - {1'b0, dcount} + (FIFO_AW+2)'(drd_en);
    dwr_en      = hold_valid && (eop_now ? (dfree >= FREE_1) : (dfree >= FREE_2));
    word_drop   = hold_valid && !eop_now && !dwr_en;
    dwr_data    = {eop_now, eop_now && pkt_ovf, hold_data};
  end

  // Output-side decode: handshake and data FIFO read strobe.
  always_comb begin
    accept   = m_axis_tvalid && m_axis_tready;
    can_load = !m_axis_tvalid || m_axis_tready;
    pay_done = (state == PAY) && accept && cur_eop;
    h2_load  = (state == H2) && accept && (dcount != '0);
    pay_load = (state == PAY) && can_load && !pay_done && (dcount != '0);
    drd_en   = h2_load || pay_load;
  end

  // Data FIFO storage.
  always_ff @(posedge aclk) begin
    if (dwr_en) dmem[dwr_ptr] <= dwr_data;
  end

  // Data FIFO pointers and occupancy; simultaneous read and write leave the level unchanged.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      dwr_ptr <= '0;
      drd_ptr <= '0;
      dcount  <= '0;
    end else begin
      if (dwr_en) dwr_ptr <= dwr_ptr + FIFO_AW'(1);
      if (drd_en) drd_ptr <= drd_ptr + FIFO_AW'(1);
      case ({dwr_en, drd_en})
        2'b10:   dcount <= dcount + (FIFO_AW+1)'(1);
        2'b01:   dcount <= dcount - (FIFO_AW+1)'(1);
        default: dcount <= dcount;
      endcase
    end
  end

  // Header FIFO storage.
  always_ff @(posedge aclk) begin
    if (hpush) hmem[hwr_ptr] <= {seq, timestamp};
  end

  // Header FIFO pointers and occupancy; an entry lives until its trailer is accepted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hwr_ptr <= '0;
      hrd_ptr <= '0;
      hcount  <= '0;
    end else begin
      if (hpush) hwr_ptr <= hwr_ptr + HDR_AW'(1);
      if (hpop)  hrd_ptr <= hrd_ptr + HDR_AW'(1);
      case ({hpush, hpop})
        2'b10:   hcount <= hcount + (HDR_AW+1)'(1);
        2'b01:   hcount <= hcount - (HDR_AW+1)'(1);
        default: hcount <= hcount;
      endcase
    end
  end

  // Input tracking: hold register, packet state, sequence number and drop counters.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hold_valid      <= 1'b0;
      hold_last       <= 1'b0;
      hold_data       <= '0;
      in_pkt          <= 1'b0;
      discard         <= 1'b0;
      seq             <= '0;
      pkt_ovf         <= 1'b0;
      packets_dropped <= '0;
      words_dropped   <= '0;
    end else begin
      hold_valid <= accept_word;
      if (accept_word) begin
        hold_last <= s_axis_tlast;
        hold_data <= s_axis_tdata;
      end
      if (word_drop) words_dropped <= words_dropped + 32'd1;
      if (eop_now)        pkt_ovf <= 1'b0;
      else if (word_drop) pkt_ovf <= 1'b1;
      // A discarded packet never reaches the hold register, so its end is
      // detected directly on the input (tlast or gap).
      if (sop) begin
        if (hfull) begin
          discard <= 1'b1;
          in_pkt  <= !s_axis_tlast;
          if (packets_dropped != '1) packets_dropped <= packets_dropped + 16'd1;
        end else begin
          discard <= 1'b0;
          in_pkt  <= 1'b1;
          seq     <= seq + 16'd1;
        end
      end else if (in_pkt && discard) begin
        if (!s_axis_tvalid || s_axis_tlast) in_pkt <= 1'b0;
      end else if (eop_now) begin
        in_pkt <= 1'b0;
      end
    end
  end

  // Output FSM with registered AXI-Stream outputs; the register reloads only when empty or accepted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      cur_eop       <= 1'b0;
      cur_ovf       <= 1'b0;
      pay_count     <= '0;
      packets_sent  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hempty) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {SYNC_WORD, hhead[79:64]};
            m_axis_tlast  <= 1'b0;
            pay_count     <= '0;
            state         <= H0;
          end
        end
        H0: begin
          if (accept) begin
            m_axis_tdata <= hhead[63:32];
            state        <= H1;
          end
        end
        H1: begin
          if (accept) begin
            m_axis_tdata <= hhead[31:0];
            state        <= H2;
          end
        end
        H2: begin
          if (accept) begin
            state <= PAY;
            if (h2_load) begin
              m_axis_tdata <= drd_data[31:0];
              cur_eop      <= drd_data[33];
              cur_ovf      <= drd_data[32];
            end else begin
              m_axis_tvalid <= 1'b0;
            end
          end
        end
        PAY: begin
          if (accept) pay_count <= pay_count + 16'd1;
          if (pay_done) begin
            m_axis_tdata <= {4'hE, cur_ovf, 11'b0, pay_count + 16'd1};
            m_axis_tlast <= 1'b1;
            state        <= TRL;
          end else if (pay_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= drd_data[31:0];
            cur_eop       <= drd_data[33];
            cur_ovf       <= drd_data[32];
          end else if (can_load) begin
            m_axis_tvalid <= 1'b0;
          end
        end
        TRL: begin
          if (accept) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            packets_sent  <= packets_sent + 32'd1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_event_framer.sv
// Testbench for event_framer: directed packets, expected output words queued
// when stimulus is driven and compared as the DUT hands them off.
module tb_event_framer;

  localparam int unsigned FIFO_AW = 4;
  localparam int unsigned HDR_AW  = 2;

  logic               aclk = 1'b0;
  logic               areset = 1'b1;
  logic               s_axis_tvalid = 1'b0;
  logic               s_axis_tlast = 1'b0;
  logic [31:0]        s_axis_tdata = '0;
  logic [63:0]        timestamp = '0;
  logic               m_axis_tvalid;
  logic               m_axis_tready = 1'b0;
  logic [31:0]        m_axis_tdata;
  logic               m_axis_tlast;
  logic [31:0]        packets_sent;
  logic [15:0]        packets_dropped;
  logic [31:0]        words_dropped;
  logic [FIFO_AW:0]   fifo_level;
  logic               busy;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] sb [$];
  int unsigned ready_mode = 0;
  logic [15:0] exp_seq = '0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = '0;

  event_framer #(
    .FIFO_AW  (FIFO_AW),
    .HDR_AW   (HDR_AW),
    .SYNC_WORD(16'hEF5A)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tdata   (s_axis_tdata),
    .timestamp      (timestamp),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .packets_sent   (packets_sent),
    .packets_dropped(packets_dropped),
    .words_dropped  (words_dropped),
    .fifo_level     (fifo_level),
    .busy           (busy)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream ready pattern: 0 = stalled, 1 = always ready, else pseudo-random.
  always @(posedge aclk) begin
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: pops the scoreboard on each handshake, checks stall stability.
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_stable", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'({1'b1, prev_word}));
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          check("out_expected", 64'(sb.size()), 64'd1);
        end else begin
          check("out_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(sb.pop_front()));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic drive(input logic v, input logic l, input logic [31:0] d);
    s_axis_tvalid = v;
    s_axis_tlast  = l;
    s_axis_tdata  = d;
    @(posedge aclk);
    #1;
  endtask

  task automatic exp_hdr(input logic [63:0] ts);
    sb.push_back({1'b0, 16'hEF5A, exp_seq});
    sb.push_back({1'b0, ts[63:32]});
    sb.push_back({1'b0, ts[31:0]});
    exp_seq = exp_seq + 16'd1;
  endtask

  task automatic exp_pay(input logic [31:0] d);
    sb.push_back({1'b0, d});
  endtask

  task automatic exp_trl(input logic ovf, input logic [15:0] cnt);
    sb.push_back({1'b1, 4'hE, ovf, 11'h000, cnt});
  endtask

  task automatic send_pkt(input int unsigned n, input logic use_last, input logic [31:0] base,
                          input logic [63:0] ts);
    timestamp = ts;
    exp_hdr(ts);
    for (int unsigned i = 0; i < n; i++) begin
      exp_pay(base + i);
      drive(1'b1, use_last && (i == n - 1), base + i);
    end
    exp_trl(1'b0, 16'(n));
    drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(posedge aclk);
    #3;
    areset = 1'b1;
    sb.delete();
    exp_seq = '0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_sent", 64'(packets_sent), 64'd0);
    check("rst_pdrop", 64'(packets_dropped), 64'd0);
    check("rst_wdrop", 64'(words_dropped), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    areset = 1'b0;

    // 4-word packet with tlast, latency of the first header word
    ready_mode = 1;
    do_reset();
    timestamp = 64'h00000001_00000010;
    exp_hdr(timestamp);
    exp_pay(32'h11); exp_pay(32'h22); exp_pay(32'h33); exp_pay(32'h44);
    exp_trl(1'b0, 16'd4);
    drive(1'b1, 1'b0, 32'h11);
    check("lat_sop_plus1", 64'(m_axis_tvalid), 64'd0);
    drive(1'b1, 1'b0, 32'h22);
    check("lat_sop_plus2_valid", 64'(m_axis_tvalid), 64'd1);
    check("lat_sop_plus2_data", 64'(m_axis_tdata), 64'hEF5A0000);
    drive(1'b1, 1'b0, 32'h33);
    drive(1'b1, 1'b1, 32'h44);
    drive(1'b0, 1'b0, 32'h0);
    wait_drain(50);
    check("t1_sent", 64'(packets_sent), 64'd1);
    check("t1_busy", 64'(busy), 64'd0);

    // Packet closed by a gap, then a second packet carrying seq 1
    do_reset();
    send_pkt(3, 1'b0, 32'hA0, 64'h00000002_00000020);
    send_pkt(2, 1'b1, 32'hB0, 64'h00000003_00000030);
    wait_drain(60);
    check("t2_sent", 64'(packets_sent), 64'd2);

    // 8-word packet under random backpressure
    ready_mode = 2;
    send_pkt(8, 1'b1, 32'hC0, 64'hDEAD0000_BEEF0004);
    wait_drain(400);
    check("t3_sent", 64'(packets_sent), 64'd3);

    // Data FIFO overflow: 40 words into 16 entries while stalled
    ready_mode = 0;
    do_reset();
    timestamp = 64'h00000004_00000040;
    exp_hdr(timestamp);
    for (int unsigned i = 0; i < 15; i++) exp_pay(32'h1000 + i);
    exp_pay(32'h1000 + 39);
    exp_trl(1'b1, 16'd16);
    for (int unsigned i = 0; i < 40; i++) drive(1'b1, i == 39, 32'h1000 + i);
    drive(1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge aclk);
    #1;
    check("t4_level", 64'(fifo_level), 64'd16);
    check("t4_wdrop", 64'(words_dropped), 64'd24);
    check("t4_stalled_tvalid", 64'(m_axis_tvalid), 64'd1);
    ready_mode = 1;
    wait_drain(200);
    check("t4_sent", 64'(packets_sent), 64'd1);
    check("t4_level_after", 64'(fifo_level), 64'd0);

    // Header FIFO full: five 1-word packets, only four fit
    ready_mode = 0;
    do_reset();
    for (int unsigned p = 0; p < 5; p++) begin
      timestamp = 64'h5000 + 64'(p);
      if (p < 4) begin
        exp_hdr(timestamp);
        exp_pay(32'h5500 + p);
        exp_trl(1'b0, 16'd1);
      end
      drive(1'b1, 1'b0, 32'h5500 + p);
      drive(1'b0, 1'b0, 32'h0);
    end
    repeat (2) @(posedge aclk);
    #1;
    check("t5_pdrop", 64'(packets_dropped), 64'd1);
    check("t5_level", 64'(fifo_level), 64'd4);
    check("t5_busy", 64'(busy), 64'd1);
    ready_mode = 1;
    wait_drain(200);
    check("t5_sent", 64'(packets_sent), 64'd4);

    // Asynchronous reset in the middle of a payload
    timestamp = 64'h00000006_00000060;
    exp_hdr(timestamp);
    for (int unsigned i = 0; i < 6; i++) begin
      exp_pay(32'hD0 + i);
      drive(1'b1, i == 5, 32'hD0 + i);
    end
    check("t6_mid_payload", 64'(m_axis_tvalid), 64'd1);
    #2;
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t6_rst_sent", 64'(packets_sent), 64'd0);
    check("t6_rst_pdrop", 64'(packets_dropped), 64'd0);
    check("t6_rst_wdrop", 64'(words_dropped), 64'd0);
    check("t6_rst_level", 64'(fifo_level), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    sb.delete();
    exp_seq = '0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    send_pkt(2, 1'b1, 32'hE0, 64'h00000007_00000070);
    wait_drain(60);
    check("t6_sent", 64'(packets_sent), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_framer.md
Name: event_framer

Overview:
- Sits directly downstream of the ADC trigger/capture stage and consumes its 32-bit sample stream. That source cannot be stalled.
- Buffers the stream in a FIFO and splits it into packets.
- Wraps each packet in a 3-word header (sync+sequence, 64-bit start timestamp) and a 1-word trailer (word count, overflow flag).
- Emits the result on a backpressured AXI-Stream master feeding the DMA/burst writer.

Parameters:
- FIFO_AW, 10, data FIFO address width; depth 2^FIFO_AW entries of 34 bits.
- HDR_AW, 2, header FIFO address width; depth 2^HDR_AW pending packet headers.
- SYNC_WORD, 16'hEF5A, upper half of header word 0.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- s_axis_tvalid  in  1  input word valid; no tready, source never stalls
- s_axis_tlast  in  1  input packet end (limiter reached)
- s_axis_tdata  in  32  input word, passed through unmodified
- timestamp  in  64  free-running sample counter, sampled at packet start
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  32  output word
- m_axis_tlast  out  1  asserted on trailer word only
- packets_sent  out  32  trailers accepted downstream
- packets_dropped  out  16  packets discarded at start (header FIFO full), saturating
- words_dropped  out  32  payload words discarded for lack of FIFO space, wrapping
- fifo_level  out  FIFO_AW+1  data FIFO occupancy
- busy  out  1  either FIFO non-empty or output FSM not IDLE

Behaviour:
- Reset (areset=1, async): all outputs 0; FIFOs emptied; seq=0; in_pkt=0; hold register invalid; FSM=IDLE. A packet in flight is truncated with no trailer.

Input side:
- SOP = s_axis_tvalid && !in_pkt.
- At SOP:
  - If header FIFO full: whole packet discarded until its end, packets_dropped+1.
  - Else push {seq, timestamp} (timestamp sampled in the same cycle), seq+1 (16-bit, wraps), in_pkt=1.
- Each valid word enters a one-word hold register. On the next cycle the held word is written to the data FIFO as entry {eop, ovf, data}.
- eop = held_tlast || !s_axis_tvalid (a gap ends the packet). in_pkt clears when eop is written.
- ovf = 1 on the eop entry if any word of this packet was dropped.
- Space rule:
  - Non-eop word written only if free ≥ 2, else dropped (words_dropped+1, packet ovf set).
  - eop word written if free ≥ 1.
  - Invariant: eop always fits.
- tlast followed by valid on the very next cycle: eop written, new SOP that same cycle.
- Simultaneous FIFO read and write at full/empty: both take effect; fifo_level unchanged.

Output FSM (states IDLE, H0, H1, H2, PAY, TRL):
- IDLE → H0 when header FIFO non-empty.
- H0 data = {SYNC_WORD, seq}. H1 = ts[63:32]. H2 = ts[31:0].
- PAY streams data FIFO entries, holding tvalid low while the FIFO is empty. Count each payload word in a 16-bit counter. When the eop entry is accepted → TRL.
- TRL data = {4'hE, ovf, 11'b0, count[15:0]}, tlast=1. On accept, pop header FIFO, packets_sent+1, → IDLE.
- Each state advances only on tvalid && tready.
- Output is registered. While tvalid && !tready, tdata/tlast are held stable. tvalid never drops without a handshake, except on reset.
- Throughput: 1 word/cycle with tready=1. First header word appears 2 cycles after the SOP input cycle. Payload follows header with no bubble if data is present.

Test Plan:
- Defaults, tready=1; 4-word packet, tlast on word 4, data 0x11..0x44, timestamp=0x00000001_00000010 at SOP → EF5A0000, 00000001, 00000010, 11,22,33,44, E0000004 with tlast; packets_sent=1.
- 3 consecutive valid words, no tlast, then tvalid low → packet closes on the gap; trailer E0000003. A second packet's header carries seq=0001.
- 8-word packet with tready toggling pseudo-randomly → output sequence identical to the tready=1 case; tdata stable on every stalled cycle.
- FIFO_AW=4, tready=0; 40-word packet ending in tlast → 16 entries stored, words_dropped=24. On release, 16 payload words, then trailer E8000010.
- HDR_AW=2, tready=0; five 1-word packets separated by gaps → packets_dropped=1. On release, exactly 4 packets with seq 0..3.
- areset pulsed mid-payload → m_axis_tvalid=0 and all counters/fifo_level=0 immediately. Next packet starts with seq=0000 and a correct header.
